// File: rtl/rtc_pkg.sv
// Shared constants, field width and set_sel encodings for the RTC timekeeper.
package rtc_pkg;

   localparam int FIELD_W = 7;

   localparam logic [FIELD_W-1:0] SEC_MAX  = 7'd59;
   localparam logic [FIELD_W-1:0] MIN_MAX  = 7'd59;
   localparam logic [FIELD_W-1:0] HOUR_MAX = 7'd23;

   typedef enum logic [1:0] {
      SEL_SEC  = 2'd0,
      SEL_MIN  = 2'd1,
      SEL_HOUR = 2'd2,
      SEL_NONE = 2'd3
   } set_sel_e;

   // Compare against the maximum before incrementing so a field never leaves its range.
   function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max_v);
      logic [FIELD_W-1:0] r;
      if (v >= max_v) begin
         r = {FIELD_W{1'b0}};
      end else begin
         r = v + 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rtc_timekeeper_counter.sv
// mod_counter: one time field, counting 0..MAX; carry_i reports wrap, inc_i never does.
module mod_counter
   import rtc_pkg::*;
#(
   parameter logic [FIELD_W-1:0] MAX = SEC_MAX
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc_i,
   input  logic               carry_i,
   output logic [FIELD_W-1:0] value_o,
   output logic [FIELD_W-1:0] value_nxt_o,
   output logic               wrap_o
);

   logic [FIELD_W-1:0] value_q;
   logic [FIELD_W-1:0] value_d;

   // Next value and carry-out for this field.
   always_comb begin
      value_d = value_q;
      wrap_o  = 1'b0;
      if (inc_i || carry_i) begin
         value_d = wrap_inc(value_q, MAX);
         wrap_o  = carry_i && (value_q == MAX);
      end else begin
         value_d = value_q;
         wrap_o  = 1'b0;
      end
   end

   // Field register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= {FIELD_W{1'b0}};
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o     = value_q;
   assign value_nxt_o = value_d;

endmodule

// File: rtl/rtc_timekeeper.sv
// RTC core: 1 Hz prescaler, hh:mm:ss chain and SET-mode adjustment.
// Optional alarm compare is built only when RTC_ALARM_EN is defined.
module rtc_timekeeper
   import rtc_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               set_mode,
   input  logic [1:0]         set_sel,
   input  logic               set_inc,
   input  logic [FIELD_W-1:0] alarm_hour,
   input  logic [FIELD_W-1:0] alarm_min,
   input  logic               alarm_arm,
   output logic [FIELD_W-1:0] hour,
   output logic [FIELD_W-1:0] min,
   output logic [FIELD_W-1:0] sec,
   output logic               tick,
   output logic               day_wrap,
   output logic               alarm
);

   localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_SET = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, day_wrap_q, alarm_q;
   logic             tick_s, alarm_d;
   logic             inc_sec_s, inc_min_s, inc_hour_s;
   logic             sec_wrap_s, min_wrap_s, hour_wrap_s;
   logic [FIELD_W-1:0] sec_nxt_s, min_nxt_s, hour_nxt_s;

   assign state_d = set_mode ? ST_SET : ST_RUN;
   assign tick_s  = (state_q == ST_RUN) && (div_q == DIV_MAX);

   // Prescaler: held at zero in SET so a partial second is discarded.
   always_comb begin
      div_d = div_q;
      if ((state_q == ST_SET) || tick_s) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Manual increment steering; only honoured while the registered state is SET.
   always_comb begin
      inc_sec_s  = 1'b0;
      inc_min_s  = 1'b0;
      inc_hour_s = 1'b0;
      if ((state_q == ST_SET) && set_inc) begin
         case (set_sel_e'(set_sel))
            SEL_SEC:  inc_sec_s  = 1'b1;
            SEL_MIN:  inc_min_s  = 1'b1;
            SEL_HOUR: inc_hour_s = 1'b1;
            SEL_NONE: inc_sec_s  = 1'b0;
            default:  inc_sec_s  = 1'b0;
         endcase
      end else begin
         inc_sec_s = 1'b0;
      end
   end

   mod_counter #(.MAX(SEC_MAX)) u_sec (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (inc_sec_s),
      .carry_i     (tick_s),
      .value_o     (sec),
      .value_nxt_o (sec_nxt_s),
      .wrap_o      (sec_wrap_s)
   );

   mod_counter #(.MAX(MIN_MAX)) u_min (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (inc_min_s),
      .carry_i     (sec_wrap_s),
      .value_o     (min),
      .value_nxt_o (min_nxt_s),
      .wrap_o      (min_wrap_s)
   );

   mod_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (inc_hour_s),
      .carry_i     (min_wrap_s),
      .value_o     (hour),
      .value_nxt_o (hour_nxt_s),
      .wrap_o      (hour_wrap_s)
   );

`ifdef RTC_ALARM_EN
   // A carry out of seconds means the new time has sec == 0 and came from a RUN tick.
   assign alarm_d = alarm_arm && sec_wrap_s &&
                    (min_nxt_s == alarm_min) && (hour_nxt_s == alarm_hour);
   logic unused_s;
   assign unused_s = &{1'b0, sec_nxt_s};
`else
   assign alarm_d = 1'b0;
   logic unused_s;
   assign unused_s = &{1'b0, alarm_hour, alarm_min, alarm_arm,
                       sec_nxt_s, min_nxt_s, hour_nxt_s};
`endif

   // State, prescaler and registered event pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         div_q      <= {DIV_W{1'b0}};
         tick_q     <= 1'b0;
         day_wrap_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         tick_q     <= tick_s;
         day_wrap_q <= hour_wrap_s;
         alarm_q    <= alarm_d;
      end
   end

   assign tick     = tick_q;
   assign day_wrap = day_wrap_q;
   assign alarm    = alarm_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed self-checking bench for rtc_timekeeper with CLK_HZ = 4.
module tb_rtc_timekeeper;

   logic       clk;
   logic       rst_n;
   logic       set_mode;
   logic [1:0] set_sel;
   logic       set_inc;
   logic [6:0] alarm_hour;
   logic [6:0] alarm_min;
   logic       alarm_arm;
   logic [6:0] hour, min, sec;
   logic       tick, day_wrap, alarm;

   int checks = 0;
   int errors = 0;

   rtc_timekeeper #(.CLK_HZ(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_mode   (set_mode),
      .set_sel    (set_sel),
      .set_inc    (set_inc),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm_arm  (alarm_arm),
      .hour       (hour),
      .min        (min),
      .sec        (sec),
      .tick       (tick),
      .day_wrap   (day_wrap),
      .alarm      (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      set_mode   = 1'b0;
      set_sel    = 2'd3;
      set_inc    = 1'b0;
      alarm_arm  = 1'b0;
      alarm_hour = 7'd0;
      alarm_min  = 7'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sets hh:mm:ss from 00:00:00 and ends at the first RUN cycle (div = 0).
   task automatic set_time(input int h, input int m, input int s);
      set_mode = 1'b1;
      step();
      set_inc = 1'b1;
      set_sel = 2'd2;
      repeat (h) step();
      set_sel = 2'd1;
      repeat (m) step();
      set_sel = 2'd0;
      repeat (s) step();
      set_inc  = 1'b0;
      set_sel  = 2'd3;
      set_mode = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic exp_tick;
      do_reset();
      checks++;
      if ({hour, min, sec, tick, day_wrap, alarm} !== 24'd0) begin
         errors++;
         $display("FAIL reset_values got %0d:%0d:%0d t%0b d%0b a%0b expected all 0",
                  hour, min, sec, tick, day_wrap, alarm);
      end
      for (int c = 1; c <= 5; c++) begin
         step();
         exp_tick = (c == 4);
         checks++;
         if (tick !== exp_tick) begin
            errors++;
            $display("FAIL first_tick cycle %0d got %0b expected %0b", c, tick, exp_tick);
         end
      end
      checks++;
      if ({hour, min, sec} !== {7'd0, 7'd0, 7'd1}) begin
         errors++;
         $display("FAIL first_second got %0d:%0d:%0d expected 0:0:1", hour, min, sec);
      end
   endtask

   task automatic test_day_wrap();
      logic [20:0] exp_time;
      do_reset();
      set_time(23, 59, 58);
      checks++;
      if ({hour, min, sec} !== {7'd23, 7'd59, 7'd58}) begin
         errors++;
         $display("FAIL set_time got %0d:%0d:%0d expected 23:59:58", hour, min, sec);
      end
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c < 4)      exp_time = {7'd23, 7'd59, 7'd58};
         else if (c < 8) exp_time = {7'd23, 7'd59, 7'd59};
         else            exp_time = 21'd0;
         checks++;
         if ({hour, min, sec} !== exp_time || tick !== (c == 4 || c == 8) || day_wrap !== (c == 8)) begin
            errors++;
            $display("FAIL day_wrap cycle %0d got %0d:%0d:%0d t%0b d%0b expected %0d:%0d:%0d t%0b d%0b",
                     c, hour, min, sec, tick, day_wrap, exp_time[20:14], exp_time[13:7],
                     exp_time[6:0], (c == 4 || c == 8), (c == 8));
         end
      end
   endtask

   task automatic test_set_fields();
      do_reset();
      set_time(5, 0, 0);
      set_mode = 1'b1;
      step();
      set_sel = 2'd1;
      set_inc = 1'b1;
      repeat (59) step();
      checks++;
      if (min !== 7'd59) begin
         errors++;
         $display("FAIL set_min_59 got %0d expected 59", min);
      end
      step();
      checks++;
      if ({hour, min, sec} !== {7'd5, 7'd0, 7'd0}) begin
         errors++;
         $display("FAIL set_min_wrap got %0d:%0d:%0d expected 5:0:0", hour, min, sec);
      end
      set_sel = 2'd3;
      repeat (5) step();
      checks++;
      if ({hour, min, sec} !== {7'd5, 7'd0, 7'd0}) begin
         errors++;
         $display("FAIL sel_none got %0d:%0d:%0d expected 5:0:0", hour, min, sec);
      end
      // set_mode falls together with set_inc: the increment still lands.
      set_sel  = 2'd0;
      set_mode = 1'b0;
      step();
      checks++;
      if (sec !== 7'd1) begin
         errors++;
         $display("FAIL inc_on_exit got %0d expected 1", sec);
      end
      step();
      set_inc = 1'b0;
      checks++;
      if (sec !== 7'd1) begin
         errors++;
         $display("FAIL inc_in_run got %0d expected 1", sec);
      end
   endtask

   task automatic test_partial_second();
      do_reset();
      repeat (4) step();
      repeat (2) step();
      set_mode = 1'b1;
      repeat (10) step();
      set_mode = 1'b0;
      step();
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if (tick !== (c == 4)) begin
            errors++;
            $display("FAIL resume_tick cycle %0d got %0b expected %0b", c, tick, (c == 4));
         end
      end
      checks++;
      if (sec !== 7'd2) begin
         errors++;
         $display("FAIL resume_sec got %0d expected 2", sec);
      end
   endtask

   task automatic test_alarm();
      logic exp_alarm;
      for (int armed = 1; armed >= 0; armed--) begin
         do_reset();
         alarm_hour = 7'd7;
         alarm_min  = 7'd30;
         alarm_arm  = 1'b1;
         set_time(7, 29, 59);
         alarm_arm  = armed[0];
         for (int c = 1; c <= 6; c++) begin
            step();
`ifdef RTC_ALARM_EN
            exp_alarm = (c == 4) && (armed == 1);
`else
            exp_alarm = 1'b0;
`endif
            checks++;
            if (alarm !== exp_alarm) begin
               errors++;
               $display("FAIL alarm arm%0d cycle %0d got %0b expected %0b", armed, c, alarm, exp_alarm);
            end
         end
         checks++;
         if ({hour, min, sec} !== {7'd7, 7'd30, 7'd0}) begin
            errors++;
            $display("FAIL alarm_time got %0d:%0d:%0d expected 7:30:0", hour, min, sec);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_time(12, 34, 56);
      repeat (2) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({hour, min, sec, tick, day_wrap, alarm} !== 24'd0) begin
         errors++;
         $display("FAIL async_reset got %0d:%0d:%0d t%0b d%0b a%0b expected all 0",
                  hour, min, sec, tick, day_wrap, alarm);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if (tick !== (c == 4)) begin
            errors++;
            $display("FAIL post_reset_tick cycle %0d got %0b expected %0b", c, tick, (c == 4));
         end
      end
      checks++;
      if ({hour, min, sec} !== {7'd0, 7'd0, 7'd1}) begin
         errors++;
         $display("FAIL post_reset_time got %0d:%0d:%0d expected 0:0:1", hour, min, sec);
      end
   endtask

   initial begin
      test_reset();
      test_day_wrap();
      test_set_fields();
      test_partial_second();
      test_alarm();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
